rd53_adc_sar12: RTL and testbench

//  Behavioural RNM model of a 12-bit successive-approximation ADC, the converse of the 12-bit voltage DAC.
//  - Samples a real-valued analog input on request and resolves it MSB-first, one bit per clock.
//  - Returns the binary code through a START/DONE handshake.
//  - Sits in the monitoring block; converts DAC outputs and analog mux voltages for readback.

---
 rtl/rd53_adc_pkg.sv | 12 +
 rtl/rd53_adc_comparator.sv | 12 +
 rtl/rd53_adc_sar12.sv | 103 ++++++++++
 tb/tb_rd53_adc_sar12.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rd53_adc_pkg.sv
// Shared types and helpers for the rd53 12-bit SAR ADC model.
package rd53_adc_pkg;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE_ST} adc_state_t;

  localparam int ADC_NBITS_DEFAULT = 12;

  function automatic real adc_lsb(real vp, real vn, int n);
    return (vp - vn) / real'(1 << n);
  endfunction

endpackage

// File: rtl/rd53_adc_comparator.sv
// Ideal comparator: decides whether the offset-corrected input reaches the trial level.
module rd53_adc_comparator #(
  parameter real OFFSET = 0.0
) (
  input  real  vp,
  input  real  vn,
  output logic decision
);

  always_comb decision = (vp + OFFSET) >= vn;

endmodule

// File: rtl/rd53_adc_sar12.sv
// Behavioural 12-bit SAR ADC: sample on START, resolve MSB-first one bit per clock.
module rd53_adc_sar12
  import rd53_adc_pkg::*;
#(
  parameter int  NBITS         = ADC_NBITS_DEFAULT,
  parameter int  SAMPLE_CYCLES = 1,
  parameter real COMP_OFFSET   = 0.0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  real              vin,
  input  real              vref_p,
  input  real              vref_n,
  output logic [NBITS-1:0] dout,
  output logic             busy,
  output logic             done,
  inout  wire              vdda,
  inout  wire              gnda,
  inout  wire              vsub
);

  localparam int PTR_W = $clog2(NBITS);
  localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  adc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] ptr_q;
  logic [NBITS-1:0] trial_q, trial_nx;
  real              vin_q, vrefn_q, lsb_q, thresh;
  logic             degen_q;
  logic             keep;
  logic             start_req;
  logic             sample_last;
  logic             unused_supply;

  assign unused_supply = vdda ^ gnda ^ vsub;

  // Only a clean logic 1 requests a conversion; X/Z fall through as no request.
  assign start_req   = (start == 1'b1);
  assign sample_last = (cnt_q == CNT_W'(SAMPLE_CYCLES - 1));
  assign thresh      = vrefn_q + real'(trial_q) * lsb_q;

  rd53_adc_comparator #(
    .OFFSET   (COMP_OFFSET)
  ) u_comp (
    .vp       (vin_q),
    .vn       (thresh),
    .decision (keep)
  );

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE_ST);
    case (state_q)
      IDLE:    if (start_req) state_d = SAMPLE;
      SAMPLE:  if (sample_last) state_d = CONVERT;
      CONVERT: if (ptr_q == '0) state_d = DONE_ST;
      DONE_ST: state_d = start_req ? SAMPLE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Resolve the current bit, then arm the next lower one as the new trial.
  always_comb begin
    trial_nx = trial_q;
    if (!keep) trial_nx[ptr_q] = 1'b0;
    if (ptr_q != '0) trial_nx[ptr_q - PTR_W'(1)] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      trial_q <= '0;
      vin_q   <= 0.0;
      vrefn_q <= 0.0;
      lsb_q   <= 0.0;
      degen_q <= 1'b0;
      dout    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == SAMPLE && !sample_last) ? cnt_q + CNT_W'(1) : '0;
      if (state_q == SAMPLE && sample_last) begin
        vin_q   <= vin;
        vrefn_q <= vref_n;
        lsb_q   <= adc_lsb(vref_p, vref_n, NBITS);
        degen_q <= (vref_p <= vref_n);
        trial_q <= {1'b1, {(NBITS-1){1'b0}}};
        ptr_q   <= PTR_W'(NBITS - 1);
      end
      if (state_q == CONVERT) begin
        trial_q <= trial_nx;
        ptr_q   <= ptr_q - PTR_W'(1);
        // Publish on the last bit so DOUT is already valid in the DONE cycle.
        if (ptr_q == '0) dout <= degen_q ? '0 : trial_nx;
      end
    end
  end

endmodule

// File: tb/tb_rd53_adc_sar12.sv
// Self-checking bench for rd53_adc_sar12: ideal transfer model plus directed conversions.
module tb_rd53_adc_sar12;

  localparam int NB  = 12;
  localparam int LAT = 14;
  localparam int SC  = 1;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          start;
  real           vin, vref_p, vref_n;
  logic [NB-1:0] dout;
  logic          busy, done;
  wire           vdda, gnda, vsub;

  assign vdda = 1'b1;
  assign gnda = 1'b0;
  assign vsub = 1'b0;

  int checks   = 0;
  int failures = 0;

  rd53_adc_sar12 dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .start  (start),
    .vin    (vin),
    .vref_p (vref_p),
    .vref_n (vref_n),
    .dout   (dout),
    .busy   (busy),
    .done   (done),
    .vdda   (vdda),
    .gnda   (gnda),
    .vsub   (vsub)
  );

  always #5 clk = ~clk;

  // Ideal transfer: largest k in [0, 2**NB-1] with v >= vn + k*lsb.
  function automatic int ideal_code(real v, real vp, real vn);
    real lsb;
    int  k;
    int  kmax;
    kmax = (1 << NB) - 1;
    if (vp <= vn) return 0;
    lsb = (vp - vn) / 4096.0;
    if (v < vn) return 0;
    if ((v - vn) / lsb >= real'(kmax + 1)) return kmax;
    k = $rtoi((v - vn) / lsb);
    if (k < kmax && v >= vn + real'(k + 1) * lsb) k++;
    if (k > 0 && v < vn + real'(k) * lsb) k--;
    if (k < 0) k = 0;
    if (k > kmax) k = kmax;
    return k;
  endfunction

  int  m_phase;
  int  m_dout;
  real m_vin, m_vp, m_vn;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_phase <= 0;
      m_dout  <= 0;
    end else begin
      if (m_phase == 0 || m_phase == LAT) m_phase <= (start === 1'b1) ? 1 : 0;
      else m_phase <= m_phase + 1;
      if (m_phase == SC) begin
        m_vin <= vin;
        m_vp  <= vref_p;
        m_vn  <= vref_n;
      end
      if (m_phase == LAT - 1) m_dout <= ideal_code(m_vin, m_vp, m_vn);
    end
  end

  always @(negedge clk) begin
    checks = checks + 3;
    if (busy !== (m_phase != 0)) begin
      failures++;
      $display("FAIL model_busy t=%0t got=%0b exp=%0b", $time, busy, (m_phase != 0));
    end
    if (done !== (m_phase == LAT)) begin
      failures++;
      $display("FAIL model_done t=%0t got=%0b exp=%0b", $time, done, (m_phase == LAT));
    end
    if (int'(dout) != m_dout) begin
      failures++;
      $display("FAIL model_dout t=%0t got=%0d exp=%0d", $time, dout, m_dout);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic conv(input real v, input int exp, input int pa, input int pb,
                      input real v2, input int step_at, input string nm);
    int edges, lat, busy_n;
    @(posedge clk); #2; vin = v; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    edges = 1; lat = 0; busy_n = 0;
    while (lat == 0 && edges < 40) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) lat = edges;
      else begin
        @(posedge clk); edges++; #2;
        start = (edges == pa || edges == pb);
        if (step_at != 0 && edges == step_at) vin = v2;
      end
    end
    start = 1'b0;
    chk({nm, "_latency"}, lat, LAT);
    chk({nm, "_busy_cycles"}, busy_n, LAT);
    chk({nm, "_dout"}, int'(dout), exp);
    @(posedge clk); #2;
    @(negedge clk);
    chk({nm, "_idle_after"}, int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  codes[5];
    int  edges, lat;
    real lsb;
    codes  = '{0, 1, 2047, 4094, 4095};
    rst_b  = 1'b0;
    start  = 1'b0;
    vin    = 0.0;
    vref_p = 1.2;
    vref_n = 0.0;
    lsb    = 1.2 / 4096.0;
    #3;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_dout", int'(dout), 0);
    @(posedge clk); #2; rst_b = 1'b1;

    chk("model_pin_mid", ideal_code(0.6, 1.2, 0.0), 2048);
    chk("model_pin_1000", ideal_code(1000.5 * lsb, 1.2, 0.0), 1000);
    chk("model_pin_step", ideal_code(0.2, 1.2, 0.0), 682);

    conv(0.6, 2048, 0, 0, 0.0, 0, "mid");
    conv(0.3, 1024, 0, 0, 0.0, 0, "quarter");
    conv(1.3, 4095, 0, 0, 0.0, 0, "over");
    conv(-0.1, 0, 0, 0, 0.0, 0, "under");
    conv(1000.5 * lsb, 1000, 0, 0, 0.0, 0, "code1000");
    for (int i = 0; i < 5; i++)
      conv(real'(codes[i]) * lsb, codes[i], 0, 0, 0.0, 0, "roundtrip");

    conv(0.31, 1058, 3, 9, 0.0, 0, "ignore_start");

    // Back-to-back: START held through the DONE cycle.
    @(posedge clk); #2; vin = 0.6; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    edges = 1; lat = 0;
    while (lat == 0 && edges < 40) begin
      @(negedge clk);
      if (done) lat = edges;
      else begin
        @(posedge clk); edges++; #2;
        if (edges == LAT - 1) begin start = 1'b1; vin = 0.95; end
      end
    end
    chk("b2b_first_latency", lat, LAT);
    chk("b2b_first_dout", int'(dout), 2048);
    @(posedge clk); #2; start = 1'b0;
    @(negedge clk);
    chk("b2b_no_gap", int'(busy), 1);
    edges = 1; lat = 0;
    while (lat == 0 && edges < 40) begin
      if (done) lat = edges;
      else begin
        @(posedge clk); edges++;
        @(negedge clk);
      end
    end
    chk("b2b_second_latency", lat, LAT);
    chk("b2b_second_dout", int'(dout), 3242);
    @(posedge clk); #2;

    // Reset while resolving bit 5.
    @(posedge clk); #2; vin = 0.9; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (7) @(posedge clk);
    #2; rst_b = 1'b0; #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_dout", int'(dout), 0);
    @(posedge clk); #2; rst_b = 1'b1;
    @(negedge clk);
    chk("rst_idle_after", int'(busy), 0);
    conv(0.6, 2048, 0, 0, 0.0, 0, "post_reset");

    conv(0.2, 682, 0, 0, 1.0, 3, "vin_step");

    vref_p = 0.5; vref_n = 0.6;
    conv(0.55, 0, 0, 0, 0.0, 0, "degenerate");
    vref_p = 1.2; vref_n = 0.0;

    @(posedge clk); #2; start = 1'bx;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("start_x_idle", int'(busy), 0);
    end
    @(posedge clk); #2; start = 1'b0;
    conv(0.3, 1024, 0, 0, 0.0, 0, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
